kara34_seq: RTL and testbench

//  Initiator (master) side of the leaf-multiplier start/done handshake: computes a 34x34 unsigned

---
 rtl/kara_pkg.sv | 18 +
 rtl/kara_combine.sv | 25 ++
 rtl/kara34_seq.sv | 157 +++++++++++++++
 tb/tb_kara34_seq.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kara_pkg.sv
// Shared types for the Karatsuba multiplier levels.
// Default widths, FSM state encoding and leaf call index.
package kara_pkg;

  localparam int KARA_HALF_W = 17;
  localparam int KARA_LEAF_W = 18;

  typedef enum logic [2:0] {
    IDLE,
    CALL,
    RELEASE,
    COMBINE,
    DONE
  } kara_state_e;

  typedef logic [1:0] call_idx_t;

endpackage

// File: rtl/kara_combine.sv
// Karatsuba recombination of the three leaf partials.
// P = z2<<2H + (zm-z2-z0)<<H + z0.
module kara_combine #(
  parameter int HALF_W = kara_pkg::KARA_HALF_W,
  parameter int LEAF_W = kara_pkg::KARA_LEAF_W
) (
  input  logic [2*LEAF_W-1:0] z0_i,
  input  logic [2*LEAF_W-1:0] z2_i,
  input  logic [2*LEAF_W-1:0] zm_i,
  output logic [4*HALF_W-1:0] p_o
);

  localparam int PW = 4 * HALF_W;
  localparam int ZW = 2 * LEAF_W;

  logic [ZW-1:0] z1;

  // zm >= z2 + z0 always, so the subtraction never wraps
  assign z1 = zm_i - z2_i - z0_i;

  assign p_o = (PW'(z2_i) << (2 * HALF_W))
             + (PW'(z1) << HALF_W)
             + PW'(z0_i);

endmodule

// File: rtl/kara34_seq.sv
// 34x34 unsigned multiplier: one Karatsuba level over an external
// 18x18 leaf, driven through a start/done level handshake.
module kara34_seq
  import kara_pkg::*;
#(
  parameter int HALF_W = KARA_HALF_W,
  parameter int LEAF_W = KARA_LEAF_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*HALF_W-1:0] A,
  input  logic [2*HALF_W-1:0] B,
  output logic                done,
  output logic [4*HALF_W-1:0] P,
  output logic                m_start,
  output logic [LEAF_W-1:0]   m_a,
  output logic [LEAF_W-1:0]   m_b,
  input  logic                m_done,
  input  logic [2*LEAF_W-1:0] m_p
);

  localparam int OPW = 2 * HALF_W;
  localparam int PW  = 4 * HALF_W;
  localparam int ZW  = 2 * LEAF_W;

  kara_state_e       state_q, state_d;
  call_idx_t         idx_q, idx_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic [ZW-1:0]     z0_q, z0_d, z2_q, z2_d, zm_q, zm_d;
  logic [PW-1:0]     p_q, p_d, p_comb;
  logic              done_q, done_d;
  logic              ms_q, ms_d;
  logic [LEAF_W-1:0] ma_q, ma_d, mb_q, mb_d;

  // Leaf operand for call i: low half, high half, or half-sum
  function automatic logic [LEAF_W-1:0] opnd(
    input call_idx_t      i,
    input logic [OPW-1:0] x
  );
    logic [HALF_W:0] s;
    s = {1'b0, x[OPW-1:HALF_W]} + {1'b0, x[HALF_W-1:0]};
    if (i == 2'd0)      opnd = LEAF_W'(x[HALF_W-1:0]);
    else if (i == 2'd1) opnd = LEAF_W'(x[OPW-1:HALF_W]);
    else                opnd = LEAF_W'(s);
  endfunction

  kara_combine #(
    .HALF_W(HALF_W),
    .LEAF_W(LEAF_W)
  ) u_combine (
    .z0_i(z0_q),
    .z2_i(z2_q),
    .zm_i(zm_q),
    .p_o (p_comb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z0_q    <= '0;
      z2_q    <= '0;
      zm_q    <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      ms_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z0_q    <= z0_d;
      z2_q    <= z2_d;
      zm_q    <= zm_d;
      p_q     <= p_d;
      done_q  <= done_d;
      ms_q    <= ms_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    z0_d    = z0_q;
    z2_d    = z2_q;
    zm_d    = zm_q;
    p_d     = p_q;
    done_d  = done_q;
    ms_d    = ms_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = 2'd0;
          ma_d    = opnd(2'd0, A);
          mb_d    = opnd(2'd0, B);
          ms_d    = 1'b1;
          state_d = CALL;
        end
      end
      CALL: begin
        if (m_done) begin
          if (idx_q == 2'd0)      z0_d = m_p;
          else if (idx_q == 2'd1) z2_d = m_p;
          else                    zm_d = m_p;
          ms_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // wait for the leaf to drop done before the next request
        if (!m_done) begin
          if (idx_q == 2'd2) begin
            state_d = COMBINE;
          end else begin
            idx_d   = idx_q + 2'd1;
            ma_d    = opnd(idx_q + 2'd1, a_q);
            mb_d    = opnd(idx_q + 2'd1, b_q);
            ms_d    = 1'b1;
            state_d = CALL;
          end
        end
      end
      COMBINE: begin
        p_d     = p_comb;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done    = done_q;
  assign P       = p_q;
  assign m_start = ms_q;
  assign m_a     = ma_q;
  assign m_b     = mb_q;

endmodule

// File: tb/tb_kara34_seq.sv
// Bench for kara34_seq with a behavioural 18x18 leaf multiplier
// and a plain-arithmetic scoreboard.
module tb_kara34_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [33:0] A, B;
  logic        done;
  logic [67:0] P;
  logic        m_start;
  logic [17:0] m_a, m_b;
  logic        m_done;
  logic [35:0] m_p;

  int          stall;
  int          cnt;
  logic [35:0] req_q[$];
  int          viol;
  int          rises;
  logic        ms_prev;
  logic [35:0] held;
  bit          was_wait;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kara34_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .done   (done),
    .P      (P),
    .m_start(m_start),
    .m_a    (m_a),
    .m_b    (m_b),
    .m_done (m_done),
    .m_p    (m_p)
  );

  // Leaf: answers one edge after seeing a request (plus stall edges)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0;
      m_p    <= '0;
      cnt    <= 0;
    end else if (m_start && !m_done) begin
      if (cnt == 0) req_q.push_back({m_a, m_b});
      if (cnt >= stall) begin
        m_done <= 1'b1;
        m_p    <= 36'(m_a) * 36'(m_b);
        cnt    <= 0;
      end else begin
        cnt <= cnt + 1;
      end
    end else if (!m_start) begin
      m_done <= 1'b0;
    end
  end

  always @(posedge clk) begin
    ms_prev <= m_start;
    if (m_start && !ms_prev) rises <= rises + 1;
    if (m_start && !m_done) begin
      if (was_wait && {m_a, m_b} !== held) viol <= viol + 1;
      held     <= {m_a, m_b};
      was_wait <= 1'b1;
    end else begin
      was_wait <= 1'b0;
    end
  end

  function automatic logic [35:0] exp_req(
    input longint unsigned a,
    input longint unsigned b,
    input int i
  );
    longint unsigned x, y;
    if (i == 0) begin
      x = a % 131072;
      y = b % 131072;
    end else if (i == 1) begin
      x = a / 131072;
      y = b / 131072;
    end else begin
      x = a % 131072 + a / 131072;
      y = b % 131072 + b / 131072;
    end
    return {x[17:0], y[17:0]};
  endfunction

  function automatic logic [67:0] exp_prod(input logic [33:0] a, input logic [33:0] b);
    logic [67:0] x, y;
    x = {34'b0, a};
    y = {34'b0, b};
    return x * y;
  endfunction

  task automatic do_op(
    input  logic [33:0] a,
    input  logic [33:0] b,
    output int          lat,
    output bit          ok
  );
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    req_q.delete();
    @(posedge clk);
    #2;
    A = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
    B = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
    lat = 0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout a=%h b=%h done=%b required 1", a, b, done);
    end
  endtask

  task automatic end_op;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_release got %b required 0", done);
    end
  endtask

  task automatic check_p(input string nm, input logic [67:0] e);
    checks++;
    if (P !== e) begin
      errors++;
      $display("FAIL %s P got %h required %h", nm, P, e);
    end
  endtask

  task automatic check_reqs(input string nm, input logic [33:0] a, input logic [33:0] b);
    checks++;
    if (req_q.size() != 3) begin
      errors++;
      $display("FAIL %s req_count got %0d required 3", nm, req_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (req_q[i] !== exp_req(a, b, i)) begin
          errors++;
          $display("FAIL %s req%0d got %h required %h", nm, i, req_q[i], exp_req(a, b, i));
        end
      end
    end
  endtask

  task automatic check_zero_outs(input string nm);
    checks++;
    if ({done, P, m_start, m_a, m_b} !== '0) begin
      errors++;
      $display("FAIL %s outs done=%b P=%h ms=%b ma=%h mb=%h required all 0",
               nm, done, P, m_start, m_a, m_b);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat;
    bit ok;
    do_op(34'd0, 34'd0, lat, ok);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL zero_latency got %0d required 13", lat);
    end
    check_p("zero", 68'd0);
    check_reqs("zero", 34'd0, 34'd0);
    end_op();
  endtask

  task automatic test_small;
    int lat;
    bit ok;
    do_op(34'd3, 34'd5, lat, ok);
    check_p("small", 68'd15);
    check_reqs("small", 34'd3, 34'd5);
    checks++;
    if (req_q.size() == 3 && req_q[2] !== {18'd3, 18'd5}) begin
      errors++;
      $display("FAIL small_req2 got %h required %h", req_q[2], {18'd3, 18'd5});
    end
    end_op();
  endtask

  task automatic test_max;
    int lat;
    bit ok;
    do_op(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, lat, ok);
    check_p("max", 68'hF_FFFF_FFF8_0000_0001);
    checks++;
    if (req_q.size() != 3 || req_q[2] !== {18'h3FFFE, 18'h3FFFE}) begin
      errors++;
      $display("FAIL max_req2 got %h required %h",
               req_q.size() == 3 ? req_q[2] : 36'h0, {18'h3FFFE, 18'h3FFFE});
    end
    end_op();
  endtask

  task automatic test_mid;
    int lat;
    bit ok;
    do_op(34'h2_0000, 34'h2_0000, lat, ok);
    check_p("mid", 68'h4_0000_0000);
    check_reqs("mid", 34'h2_0000, 34'h2_0000);
    end_op();
  endtask

  task automatic test_random;
    int lat;
    bit ok;
    logic [33:0] a, b;
    for (int n = 0; n < 30; n++) begin
      a = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
      b = {$urandom, $urandom} & 34'h3_FFFF_FFFF;
      if (n % 5 == 0) a = a & 34'h0_0001_FFFF;
      stall = $urandom_range(0, 3);
      do_op(a, b, lat, ok);
      check_p("random", exp_prod(a, b));
      check_reqs("random", a, b);
      end_op();
    end
    stall = 0;
  endtask

  task automatic test_hold;
    int lat;
    bit ok;
    int base;
    logic [67:0] e;
    e = exp_prod(34'h1_2345_6789, 34'h2_ABCD_0123);
    do_op(34'h1_2345_6789, 34'h2_ABCD_0123, lat, ok);
    check_p("hold_first", e);
    base = rises;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || P !== e || m_start !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle%0d done=%b P=%h ms=%b required 1 %h 0",
                 i, done, P, m_start, e);
      end
    end
    checks++;
    if (rises != base) begin
      errors++;
      $display("FAIL hold_rises got %0d required %0d", rises, base);
    end
    end_op();
    do_op(34'd7, 34'd9, lat, ok);
    check_p("hold_reraise", 68'd63);
    end_op();
  endtask

  task automatic test_drop_start;
    int hi;
    bit seen;
    logic [67:0] e;
    e = exp_prod(34'h0_FEDC_BA98, 34'h3_0000_0011);
    @(negedge clk);
    A = 34'h0_FEDC_BA98;
    B = 34'h3_0000_0011;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    hi = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        hi++;
        seen = 1'b1;
        checks++;
        if (P !== e) begin
          errors++;
          $display("FAIL drop_p got %h required %h", P, e);
        end
      end else if (seen) begin
        break;
      end
    end
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL drop_done_cycles got %0d required 1", hi);
    end
    check_p("drop_retain", e);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit ok;
    int base;
    bit hit;
    base = rises;
    hit = 1'b0;
    @(negedge clk);
    A = 34'h2_5555_AAAA;
    B = 34'h1_3333_CCCC;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (rises == base + 2) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_reach rises=%0d required %0d", rises, base + 2);
    end
    #1;
    rst = 1'b1;
    #1;
    check_zero_outs("rst_async");
    @(posedge clk);
    #1;
    check_zero_outs("rst_next");
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    do_op(34'd1000, 34'd1000, lat, ok);
    check_p("after_rst", 68'd1000000);
    end_op();
  endtask

  task automatic test_stall;
    int lat;
    bit ok;
    int v0;
    logic [33:0] a, b;
    a = 34'h3_1234_5678;
    b = 34'h2_8765_4321;
    stall = 5;
    v0 = viol;
    do_op(a, b, lat, ok);
    check_p("stall", exp_prod(a, b));
    check_reqs("stall", a, b);
    checks++;
    if (viol != v0) begin
      errors++;
      $display("FAIL stall_stability violations got %0d required 0", viol - v0);
    end
    end_op();
    stall = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    stall = 0;
    viol = 0;
    rises = 0;
    test_reset();
    test_zero();
    test_small();
    test_max();
    test_mid();
    test_random();
    test_hold();
    test_drop_start();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
